// File: rtl/pipe_register.sv
// Elastic valid/ready pipeline register: single-entry (SKID=0) or two-entry
// skid stage with flop-driven in_ready (SKID=1), with synchronous flush.
module pipe_register #(
    parameter int unsigned          WIDTH   = 32,
    parameter logic [WIDTH-1:0]     INITIAL = '0,
    parameter bit                   SKID    = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    // Encoding is {main_v, skid_v}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             main_v, skid_v;
    logic             xfer_in, xfer_out;
    logic             load_main_in, load_main_skid, load_skid;

    assign main_v    = state_q[1];
    assign skid_v    = state_q[0];
    assign out_valid = main_v;
    assign out_data  = main_q;
    assign count     = {1'b0, main_v} + {1'b0, skid_v};
    assign in_ready  = SKID ? !skid_v : (!main_v || out_ready);
    assign xfer_in   = in_valid && in_ready;
    assign xfer_out  = main_v && out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (SKID) begin
            case (state_q)
                EMPTY: begin
                    if (xfer_in) begin
                        state_d      = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (xfer_in && xfer_out) begin
                        load_main_in = 1'b1;
                    end else if (xfer_in) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (xfer_out) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (xfer_out) begin
                        state_d        = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end else begin
            if (xfer_in) begin
                state_d      = ONE;
                load_main_in = 1'b1;
            end else if (xfer_out) begin
                state_d = EMPTY;
            end
        end
        // Flush wins over any transfer and leaves the data registers untouched.
        if (flush) begin
            state_d        = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            main_q <= INITIAL;
            skid_q <= INITIAL;
        end else begin
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule
